// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N clock-chain counter: direction codes,
// default chain moduli and the binary-to-BCD split used by the optional BCD outputs.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Valid for 0..99 only; callers guarantee the range.
    function automatic bcd_t bcd_split(input logic [6:0] bin);
        bcd_t r;
        r.tens  = 4'(bin / 7'd10);
        r.units = 4'(bin % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/counter_mod_edge_rise.sv
// Rising-edge detector for the already-synchronised manual step input.
// Reset still samples the input so a level held through reset yields no edge.
module edge_rise (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock) begin
        prev <= in;
    end

    assign rise = in & ~prev & ~reset;

endmodule

// File: rtl/counter_mod.sv
// Parametrised modulo-N up/down counter with cascade carry/borrow, manual step
// and clamped load. Optional BCD outputs when COUNTER_MOD_BCD_OUT_EN is defined.
module counter_mod
    import counter_pkg::*;
#(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             step,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
`ifdef COUNTER_MOD_BCD_OUT_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units
`endif
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("counter_mod: MODULUS out of range for WIDTH");
    end

    logic             step_rise;
    logic             adv;
    logic             at_max;
    logic             at_zero;
    logic             data_bad;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_adv;
    logic [WIDTH-1:0] count_next;

    edge_rise u_step_edge (
        .clock (clock),
        .reset (reset),
        .in    (step),
        .rise  (step_rise)
    );

    assign adv     = (enable | step_rise) & ~load & ~reset;
    assign at_max  = (count == MAX_CNT);
    assign at_zero = (count == '0);

    assign carry  = adv & (up_down == DIR_UP) & at_max;
    assign borrow = adv & (up_down == DIR_DOWN) & at_zero;

    assign data_bad = ({1'b0, data} >= MOD_EXT);
    assign load_val = data_bad ? MAX_CNT : data;

    // ">=" on the up path lets a corrupted out-of-range count recover to 0.
    always_comb begin
        count_adv = count;
        if (up_down == DIR_UP) begin
            count_adv = (count >= MAX_CNT) ? '0 : count + 1'b1;
        end else begin
            count_adv = at_zero ? MAX_CNT : count - 1'b1;
        end
    end

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (adv) begin
            count_next = count_adv;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            load_err <= 1'b0;
        end else begin
            count    <= count_next;
            load_err <= load & data_bad;
        end
    end

`ifdef COUNTER_MOD_BCD_OUT_EN
    if (MODULUS > 100) begin : g_bad_bcd
        $error("counter_mod: BCD outputs need MODULUS <= 100");
    end

    bcd_t bcd_next;

    assign bcd_next = bcd_split(7'(count_next));

    always_ff @(posedge clock) begin
        if (reset) begin
            bcd_tens  <= 4'd0;
            bcd_units <= 4'd0;
        end else begin
            bcd_tens  <= bcd_next.tens;
            bcd_units <= bcd_next.units;
        end
    end
`endif

endmodule
